// File: rtl/apb4_master_pkg.sv
// Shared types and constants for the APB4 master: FSM state encoding and
// the {psel, penable} pair driven in each bus phase.
package apb4_master_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // {psel, penable} per APB4 phase
  localparam logic [1:0] PHASE_IDLE   = 2'b00;
  localparam logic [1:0] PHASE_SETUP  = 2'b10;
  localparam logic [1:0] PHASE_ACCESS = 2'b11;

  function automatic logic [1:0] phase_of(input state_e st);
    logic [1:0] ph;
    ph = PHASE_IDLE;
    case (st)
      ST_SETUP:  ph = PHASE_SETUP;
      ST_ACCESS: ph = PHASE_ACCESS;
      default:   ph = PHASE_IDLE;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/apb4_master_if.sv
// Request, response and APB4 bus signals of apb4_master; the master modport
// is the design side, the slave modport the requester/APB-slave side.
interface apb4_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic                  req_write_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic [STRB_WIDTH-1:0] req_strb_i;
  logic [2:0]            req_prot_i;

  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  rsp_err_o;
  logic                  rsp_timeout_o;

  logic [ADDR_WIDTH-1:0] paddr_o;
  logic [2:0]            pprot_o;
  logic                  psel_o;
  logic                  penable_o;
  logic                  pwrite_o;
  logic [DATA_WIDTH-1:0] pwdata_o;
  logic [STRB_WIDTH-1:0] pstrb_o;
  logic                  pready_i;
  logic [DATA_WIDTH-1:0] prdata_i;
  logic                  pslverr_i;

  modport master (
    input  req_valid_i, req_addr_i, req_write_i, req_wdata_i, req_strb_i, req_prot_i,
    output req_ready_o,
    output rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
    input  rsp_ready_i,
    output paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
    input  pready_i, prdata_i, pslverr_i
  );

  modport slave (
    output req_valid_i, req_addr_i, req_write_i, req_wdata_i, req_strb_i, req_prot_i,
    input  req_ready_o,
    input  rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
    output rsp_ready_i,
    input  paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
    output pready_i, prdata_i, pslverr_i
  );

endinterface

// File: rtl/dffer.sv
// Register library cell: load-enable flop with synchronous active-high reset to zero.
module dffer #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  always_ff @(posedge i_clk) begin
    if (i_rst)     o_q <= '0;
    else if (i_en) o_q <= i_d;
  end

endmodule

// File: rtl/dffr.sv
// Register library cell: flop with synchronous active-high reset to zero.
module dffr #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  always_ff @(posedge i_clk) begin
    if (i_rst) o_q <= '0;
    else       o_q <= i_d;
  end

endmodule

// File: rtl/apb4_master.sv
// Single-outstanding APB4 master: request -> SETUP -> ACCESS -> response.
// Define APB4_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait cycles.
module apb4_master
  import apb4_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  apb4_master_if.master   bus
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [STATE_W-1:0]    r_state;
  state_e                w_state;
  state_e                w_state_nxt;
  logic                  w_accept;
  logic                  w_done;
  logic                  w_timeout;
  logic                  w_cap;

  logic [1:0]            w_phase_nxt;
  logic [1:0]            r_phase;
  logic                  w_rsp_valid_nxt;
  logic                  r_rsp_valid;
  logic [STRB_WIDTH-1:0] w_pstrb_nxt;
  logic [STRB_WIDTH-1:0] r_pstrb;
  logic [DATA_WIDTH-1:0] w_rdata_nxt;
  logic                  w_err_nxt;

  logic [ADDR_WIDTH-1:0] r_paddr;
  logic                  r_pwrite;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic [2:0]            r_pprot;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;

  assign w_state   = state_e'(r_state);
  assign w_accept  = bus.req_valid_i && (w_state == ST_IDLE);
  assign w_done    = (w_state == ST_ACCESS) && bus.pready_i;
  assign w_cap     = w_done || w_timeout;

  assign bus.req_ready_o = (w_state == ST_IDLE);

  // State register
  dffr #(.WIDTH(STATE_W)) u_state (
    .i_clk(clk_i), .i_rst(rst_i), .i_d(w_state_nxt), .o_q(r_state)
  );

  // Next-state logic
  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      ST_IDLE:   if (w_accept) w_state_nxt = ST_SETUP;
      ST_SETUP:  w_state_nxt = ST_ACCESS;
      ST_ACCESS: if (w_cap) w_state_nxt = ST_RESP;
      ST_RESP:   if (bus.rsp_ready_i) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: next values for the registered bus and response outputs
  always_comb begin
    w_phase_nxt     = phase_of(w_state_nxt);
    w_rsp_valid_nxt = (w_state_nxt == ST_RESP);
    w_pstrb_nxt     = '0;
    case (w_state_nxt)
      ST_SETUP:  w_pstrb_nxt = bus.req_write_i ? bus.req_strb_i : '0;
      ST_ACCESS: w_pstrb_nxt = r_pstrb;
      default:   w_pstrb_nxt = '0;
    endcase
    // A timeout capture returns zero data and an error
    w_rdata_nxt = '0;
    w_err_nxt   = 1'b1;
    if (w_done) begin
      w_rdata_nxt = r_pwrite ? '0 : bus.prdata_i;
      w_err_nxt   = bus.pslverr_i;
    end
  end

  dffr #(.WIDTH(2)) u_phase (
    .i_clk(clk_i), .i_rst(rst_i), .i_d(w_phase_nxt), .o_q(r_phase)
  );
  dffr #(.WIDTH(1)) u_rsp_valid (
    .i_clk(clk_i), .i_rst(rst_i), .i_d(w_rsp_valid_nxt), .o_q(r_rsp_valid)
  );
  dffr #(.WIDTH(STRB_WIDTH)) u_pstrb (
    .i_clk(clk_i), .i_rst(rst_i), .i_d(w_pstrb_nxt), .o_q(r_pstrb)
  );

  // Request capture, held stable for the whole SETUP/ACCESS window
  dffer #(.WIDTH(ADDR_WIDTH)) u_paddr (
    .i_clk(clk_i), .i_rst(rst_i), .i_en(w_accept), .i_d(bus.req_addr_i), .o_q(r_paddr)
  );
  dffer #(.WIDTH(1)) u_pwrite (
    .i_clk(clk_i), .i_rst(rst_i), .i_en(w_accept), .i_d(bus.req_write_i), .o_q(r_pwrite)
  );
  dffer #(.WIDTH(DATA_WIDTH)) u_pwdata (
    .i_clk(clk_i), .i_rst(rst_i), .i_en(w_accept), .i_d(bus.req_wdata_i), .o_q(r_pwdata)
  );
  dffer #(.WIDTH(3)) u_pprot (
    .i_clk(clk_i), .i_rst(rst_i), .i_en(w_accept), .i_d(bus.req_prot_i), .o_q(r_pprot)
  );

  // Response capture on ACCESS exit; frozen while the response waits
  dffer #(.WIDTH(DATA_WIDTH)) u_rsp_rdata (
    .i_clk(clk_i), .i_rst(rst_i), .i_en(w_cap), .i_d(w_rdata_nxt), .o_q(r_rsp_rdata)
  );
  dffer #(.WIDTH(1)) u_rsp_err (
    .i_clk(clk_i), .i_rst(rst_i), .i_en(w_cap), .i_d(w_err_nxt), .o_q(r_rsp_err)
  );

`ifdef APB4_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 2);

  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_wait_cnt_nxt;
  logic             r_rsp_timeout;
  logic             w_waiting;

  // Counts consecutive ACCESS cycles without pready; pready wins on the expiry cycle
  assign w_waiting      = (w_state == ST_ACCESS) && !bus.pready_i;
  assign w_timeout      = w_waiting && (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_wait_cnt_nxt = (w_waiting && !w_timeout) ? CNT_W'(r_wait_cnt + 1'b1) : '0;

  dffr #(.WIDTH(CNT_W)) u_wait_cnt (
    .i_clk(clk_i), .i_rst(rst_i), .i_d(w_wait_cnt_nxt), .o_q(r_wait_cnt)
  );
  dffer #(.WIDTH(1)) u_rsp_timeout (
    .i_clk(clk_i), .i_rst(rst_i), .i_en(w_cap), .i_d(!w_done), .o_q(r_rsp_timeout)
  );

  assign bus.rsp_timeout_o = r_rsp_timeout;
`else
  assign w_timeout         = 1'b0;
  assign bus.rsp_timeout_o = 1'b0;
`endif

  assign bus.psel_o      = r_phase[1];
  assign bus.penable_o   = r_phase[0];
  assign bus.pstrb_o     = r_pstrb;
  assign bus.paddr_o     = r_paddr;
  assign bus.pwrite_o    = r_pwrite;
  assign bus.pwdata_o    = r_pwdata;
  assign bus.pprot_o     = r_pprot;
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_rdata_o = r_rsp_rdata;
  assign bus.rsp_err_o   = r_rsp_err;

endmodule

// File: tb/tb_apb4_master.sv
// Self-checking bench for apb4_master: directed and random transfers checked
// against a transaction-level model of the expected bus and response behaviour.
module tb_apb4_master;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned TO = 8;
`ifdef APB4_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  apb4_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb4_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One complete transfer; the model derives every expectation from the request
  task automatic do_xfer(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [SW-1:0] strb, input logic [2:0] prot, input int waits,
                         input bit slverr, input logic [DW-1:0] rdata, input int bp);
    bit              exp_to;
    int              access_cycles;
    logic [SW-1:0]   exp_strb;
    logic [DW-1:0]   exp_rdata;
    bit              exp_err;
    bit              last;

    exp_to        = TO_EN && (waits >= int'(TO));
    access_cycles = exp_to ? int'(TO) : waits + 1;
    exp_strb      = wr ? strb : '0;
    exp_rdata     = (exp_to || wr) ? '0 : rdata;
    exp_err       = exp_to ? 1'b1 : slverr;

    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_write_i = wr;
    bus.req_addr_i  = addr;
    bus.req_wdata_i = wdata;
    bus.req_strb_i  = strb;
    bus.req_prot_i  = prot;
    check("idle_ready", 64'(bus.req_ready_o), 64'(1));

    @(negedge clk);
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = $urandom;
    bus.req_wdata_i = $urandom;
    bus.req_strb_i  = SW'($urandom);
    bus.req_write_i = ~wr;
    bus.req_prot_i  = 3'($urandom);
    check("setup_psel", 64'(bus.psel_o), 64'(1));
    check("setup_penable", 64'(bus.penable_o), 64'(0));
    check("setup_paddr", 64'(bus.paddr_o), 64'(addr));
    check("setup_pwrite", 64'(bus.pwrite_o), 64'(wr));
    check("setup_pstrb", 64'(bus.pstrb_o), 64'(exp_strb));
    check("setup_pprot", 64'(bus.pprot_o), 64'(prot));
    if (wr) check("setup_pwdata", 64'(bus.pwdata_o), 64'(wdata));
    check("setup_rsp_valid", 64'(bus.rsp_valid_o), 64'(0));

    @(negedge clk);
    for (int i = 0; i < access_cycles; i++) begin
      check("access_psel", 64'(bus.psel_o), 64'(1));
      check("access_penable", 64'(bus.penable_o), 64'(1));
      check("access_paddr", 64'(bus.paddr_o), 64'(addr));
      check("access_pstrb", 64'(bus.pstrb_o), 64'(exp_strb));
      check("access_rsp_valid", 64'(bus.rsp_valid_o), 64'(0));
      check("access_ready", 64'(bus.req_ready_o), 64'(0));
      last          = !exp_to && (i == access_cycles - 1);
      bus.pready_i  = last;
      bus.prdata_i  = last ? rdata : DW'($urandom);
      bus.pslverr_i = last ? slverr : 1'($urandom);
      @(negedge clk);
    end
    bus.pready_i  = 1'b0;
    bus.prdata_i  = $urandom;
    bus.pslverr_i = 1'b0;

    for (int b = 0; b <= bp; b++) begin
      check("resp_valid", 64'(bus.rsp_valid_o), 64'(1));
      check("resp_rdata", 64'(bus.rsp_rdata_o), 64'(exp_rdata));
      check("resp_err", 64'(bus.rsp_err_o), 64'(exp_err));
      check("resp_timeout", 64'(bus.rsp_timeout_o), 64'(exp_to));
      check("resp_psel", 64'(bus.psel_o), 64'(0));
      check("resp_penable", 64'(bus.penable_o), 64'(0));
      check("resp_pstrb", 64'(bus.pstrb_o), 64'(0));
      check("resp_ready", 64'(bus.req_ready_o), 64'(0));
      bus.rsp_ready_i = (b == bp);
      bus.req_valid_i = (b < bp);
      @(negedge clk);
    end
    bus.rsp_ready_i = 1'b0;
    bus.req_valid_i = 1'b0;
    check("done_rsp_valid", 64'(bus.rsp_valid_o), 64'(0));
    check("done_req_ready", 64'(bus.req_ready_o), 64'(1));
    check("done_psel", 64'(bus.psel_o), 64'(0));
  endtask

  initial begin
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_write_i = 1'b0;
    bus.req_wdata_i = '0;
    bus.req_strb_i  = '0;
    bus.req_prot_i  = '0;
    bus.rsp_ready_i = 1'b0;
    bus.pready_i    = 1'b0;
    bus.prdata_i    = '0;
    bus.pslverr_i   = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_psel", 64'(bus.psel_o), 64'(0));
    check("rst_penable", 64'(bus.penable_o), 64'(0));
    check("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'(0));
    check("rst_rdata", 64'(bus.rsp_rdata_o), 64'(0));
    check("rst_err", 64'(bus.rsp_err_o), 64'(0));
    check("rst_paddr", 64'(bus.paddr_o), 64'(0));
    check("rst_pstrb", 64'(bus.pstrb_o), 64'(0));
    check("rst_req_ready", 64'(bus.req_ready_o), 64'(1));
    rst = 1'b0;

    // Zero-wait write
    do_xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'd0, 0, 1'b0, 32'h0, 0);
    // Read with three wait states
    do_xfer(1'b0, 32'h20, 32'h0, 4'hF, 3'd2, 3, 1'b0, 32'h12345678, 0);
    // Slave error
    do_xfer(1'b0, 32'h30, 32'h0, 4'h0, 3'd1, 1, 1'b1, 32'hCAFEF00D, 0);
    // Response backpressure with an ignored request
    do_xfer(1'b0, 32'h40, 32'h0, 4'h0, 3'd0, 0, 1'b0, 32'hA5A5A5A5, 5);
    // Long stall: timeout when enabled, otherwise an indefinite wait
    do_xfer(1'b0, 32'h50, 32'h0, 4'h0, 3'd0, 20, 1'b0, 32'h77777777, 1);
    do_xfer(1'b1, 32'h54, 32'h11223344, 4'h5, 3'd7, 7, 1'b0, 32'h0, 0);

    for (int t = 0; t < 20; t++) begin
      do_xfer(1'($urandom), $urandom, $urandom, SW'($urandom), 3'($urandom),
              $urandom_range(0, 4), ($urandom_range(0, 3) == 0), $urandom,
              $urandom_range(0, 3));
    end

    // Reset while in ACCESS abandons the transfer
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_write_i = 1'b0;
    bus.req_addr_i  = 32'h60;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    check("pre_rst_penable", 64'(bus.penable_o), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    rst          = 1'b0;
    bus.pready_i = 1'b1;
    check("post_rst_psel", 64'(bus.psel_o), 64'(0));
    check("post_rst_penable", 64'(bus.penable_o), 64'(0));
    check("post_rst_rsp_valid", 64'(bus.rsp_valid_o), 64'(0));
    check("post_rst_req_ready", 64'(bus.req_ready_o), 64'(1));
    @(negedge clk);
    bus.pready_i = 1'b0;
    check("post_rst_no_rsp", 64'(bus.rsp_valid_o), 64'(0));
    check("post_rst_idle_psel", 64'(bus.psel_o), 64'(0));

    // Still functional after the abandoned transfer
    do_xfer(1'b0, 32'h70, 32'h0, 4'h0, 3'd0, 2, 1'b0, 32'h0BADC0DE, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/apb4_master.md
APB4_MASTER -- requirements
Module: apb4_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB data width (multiple of 8).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum ACCESS-phase wait cycles (only used with APB4_MASTER_TIMEOUT_EN).
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk_i input 1 (clock); rst_i input 1 (reset).
REQ-005 SHALL have the request ports req_valid_i in 1; req_ready_o out 1; req_addr_i in ADDR_WIDTH; req_write_i in 1; req_wdata_i in DATA_WIDTH; req_strb_i in DATA_WIDTH/8; req_prot_i in 3.
REQ-006 SHALL have the response ports rsp_valid_o out 1; rsp_ready_i in 1; rsp_rdata_o out DATA_WIDTH; rsp_err_o out 1 (slave error or timeout); rsp_timeout_o out 1.
REQ-007 SHALL have the APB4 ports paddr_o out ADDR_WIDTH; pprot_o out 3; psel_o out 1; penable_o out 1; pwrite_o out 1; pwdata_o out DATA_WIDTH; pstrb_o out DATA_WIDTH/8; pready_i in 1; prdata_i in DATA_WIDTH; pslverr_i in 1.

Function
REQ-008 SHALL implement the FSM states IDLE, SETUP, ACCESS and RESP.
REQ-009 SHALL assert req_ready_o combinationally only in IDLE; a request is accepted when req_valid_i && req_ready_o.
REQ-010 SHALL, on acceptance, register addr, write, wdata, strb and prot, and go to SETUP.
REQ-011 SHALL drive psel_o=1 and penable_o=0 in SETUP, and move to ACCESS unconditionally after exactly one cycle.
REQ-012 SHALL drive psel_o=1 and penable_o=1 in ACCESS, and stay in ACCESS while pready_i=0.
REQ-013 SHALL, in ACCESS with pready_i=1, capture prdata_i into rsp_rdata_o for reads (zero for writes), set rsp_err_o=pslverr_i, and go to RESP.
REQ-014 SHALL drive psel_o, penable_o and pstrb_o low in RESP, and hold rsp_valid_o=1 until rsp_ready_i=1; on that handshake it returns to IDLE.
REQ-015 SHALL hold paddr_o, pwrite_o, pwdata_o, pstrb_o and pprot_o stable from the SETUP cycle through the final ACCESS cycle.
REQ-016 SHALL drive pstrb_o to 0 for reads.
REQ-017 SHALL sample pready_i, prdata_i and pslverr_i only in ACCESS.
REQ-018 SHALL give a minimum latency of 3 cycles from acceptance to rsp_valid_o (SETUP, ACCESS, RESP); the minimum period is 4 cycles per transfer.
REQ-019 SHALL hold rsp_rdata_o, rsp_err_o and rsp_timeout_o stable while rsp_valid_o=1.
REQ-020 SHALL ignore req_valid_i outside IDLE; no request is queued.

Reset
REQ-021 SHALL, when rst_i=1 at a clock edge, force state IDLE, all registered outputs to 0, and the timeout counter to 0.
REQ-022 SHALL abandon any transfer when reset occurs mid-operation: psel_o=0 and rsp_valid_o=0 from the next edge, with no response emitted.

Configuration
REQ-023 SHALL, with APB4_MASTER_TIMEOUT_EN defined, count ACCESS cycles with pready_i=0; after TIMEOUT_CYCLES such cycles it aborts to RESP with rsp_err_o=1, rsp_timeout_o=1 and rsp_rdata_o=0.
REQ-024 SHALL treat pready_i=1 on the same cycle the count expires as normal completion, not a timeout.
REQ-025 SHALL, without APB4_MASTER_TIMEOUT_EN, not instantiate the counter, tie rsp_timeout_o to 0, and wait in ACCESS indefinitely.

Structure
REQ-026 SHALL define the FSM state enum typedef and the APB4 phase constants in the shared package apb4_master_pkg.
REQ-027 SHALL keep the timeout counter inline rather than in a sub-module, and build its state and capture registers from the existing register library cells (dffr/dffer).

Verification
REQ-028 SHALL cover a write with zero wait states: addr=0x10, wdata=0xDEADBEEF, strb=0xF -> SETUP 1 cycle, ACCESS 1 cycle, rsp_valid_o 3 cycles after acceptance with rsp_err_o=0.
REQ-029 SHALL cover a read with 3 wait states: pready_i low for 3 ACCESS cycles, prdata_i=0x12345678 -> rsp_rdata_o=0x12345678, pstrb_o=0 throughout, address stable for all 5 phase cycles.
REQ-030 SHALL cover a slave error: pslverr_i=1 with pready_i -> rsp_err_o=1, rsp_timeout_o=0.
REQ-031 SHALL cover response backpressure: rsp_ready_i low for 5 cycles -> rsp_valid_o and data held, req_ready_o=0, and a new req_valid_i is ignored until the handshake.
REQ-032 SHALL cover a timeout (macro on, TIMEOUT_CYCLES=8, pready_i never high) -> RESP after 8 wait cycles with rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0.
REQ-033 SHALL cover reset during ACCESS: rst_i pulsed for 1 cycle -> psel_o=0, penable_o=0, rsp_valid_o=0, req_ready_o=1 on the following cycle.
